// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester and memory handshake signals of the fetch/data memory arbiter
interface mem_bus_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  logic                 if_req;
  logic [WORD_SIZE-1:0] if_addr;
  logic [WORD_SIZE-1:0] if_rdata;
  logic                 if_done;
  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_done;
  logic                 err;
  logic                 readM;
  logic                 writeM;
  logic [WORD_SIZE-1:0] address;
  logic                 inputReady;
  logic                 ackOutput;
  logic                 busy;
  // arbiter side: masters the memory bus, serves both requesters
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, inputReady, ackOutput,
    output if_rdata, if_done, d_rdata, d_done, err, readM, writeM, address, busy
  );
  // environment side: requesters plus memory
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, inputReady, ackOutput,
    input  if_rdata, if_done, d_rdata, d_done, err, readM, writeM, address, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: single-port memory arbiter, data access beats instruction fetch, with timeout
module mem_bus_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_bus_arbiter_if.master    bus,
  inout  wire  [WORD_SIZE-1:0] data
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, DREAD, DWRITE, DONE} state_t;
  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_d_q, is_d_d, err_q, err_d;
  logic                 access, timed_out;
  assign access    = state_q == FETCH || state_q == DREAD || state_q == DWRITE;
  assign timed_out = cnt_q == CW'(TIMEOUT - 1);
  // reset_n is active-high here; it aborts any access immediately
  always_ff @(posedge clk or posedge reset_n)
    if (reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      cnt_q      <= '0;
      is_d_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      cnt_q      <= cnt_d;
      is_d_q     <= is_d_d;
      err_q      <= err_d;
    end
  // grant with data priority, wait for handshake or timeout, then one DONE cycle
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    cnt_d      = cnt_q;
    is_d_d     = is_d_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.d_req || bus.if_req) begin
          state_d = bus.d_req ? (bus.d_we ? DWRITE : DREAD) : FETCH;
          addr_d  = bus.d_req ? bus.d_addr : bus.if_addr;
          wdata_d = bus.d_wdata;
          is_d_d  = bus.d_req;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      FETCH, DREAD: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.inputReady) begin
          state_d    = DONE;
          if_rdata_d = state_q == FETCH ? data : if_rdata_q;
          d_rdata_d  = state_q == DREAD ? data : d_rdata_q;
        end else if (timed_out) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DWRITE: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.ackOutput) state_d = DONE;
        else if (timed_out) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.readM    = state_q == FETCH || state_q == DREAD;
  assign bus.writeM   = state_q == DWRITE;
  assign bus.address  = access ? addr_q : '0;
  assign bus.busy     = state_q != IDLE;
  assign bus.if_done  = state_q == DONE && !is_d_q;
  assign bus.d_done   = state_q == DONE && is_d_q;
  assign bus.err      = state_q == DONE && err_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign data         = state_q == DWRITE ? wdata_q : 'z;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and random accesses against a transaction-level memory model
module tb_mem_bus_arbiter;
  localparam int W  = 16;
  localparam int TO = 4;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  wire  [W-1:0] data;
  logic [W-1:0] mem_val = '0;
  logic [W-1:0] exp_if_rdata = '0;
  logic [W-1:0] exp_d_rdata = '0;
  logic         noise = 1'b0;
  int           hs_k = 0;
  int           strobe_cnt = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  mem_bus_arbiter_if #(.WORD_SIZE(W)) bus();
  mem_bus_arbiter #(.WORD_SIZE(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .data(data)
  );
  always #5 clk = ~clk;
  // memory drives read data whenever it is not being written, so a stray arbiter driver shows up
  assign data = bus.writeM ? {W{1'bz}} : mem_val;
  // handshake comes in the hs_k-th strobe cycle (0 = never); noise pulses the handshake that must be ignored
  assign bus.inputReady = (bus.readM && hs_k != 0 && strobe_cnt + 1 == hs_k) || (bus.writeM && noise);
  assign bus.ackOutput  = (bus.writeM && hs_k != 0 && strobe_cnt + 1 == hs_k) || (bus.readM && noise);
  // number of completed strobe cycles of the current access
  always @(posedge clk or posedge reset_n)
    strobe_cnt <= reset_n ? 0 : ((bus.readM || bus.writeM) ? strobe_cnt + 1 : 0);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_rd"}, bus.readM, 0);
    check({tag, "_wr"}, bus.writeM, 0);
    check({tag, "_addr"}, bus.address, 0);
    check({tag, "_data"}, data, mem_val);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, {bus.if_done, bus.d_done, bus.err}, 0);
    check({tag, "_ifr"}, bus.if_rdata, exp_if_rdata);
    check({tag, "_dr"}, bus.d_rdata, exp_d_rdata);
  endtask
  // caller has raised the request at a negedge while the arbiter is idle
  task automatic run_access(input logic is_d, input logic we, input logic [W-1:0] addr,
                            input logic [W-1:0] wdata, input int k, input logic nz,
                            input logic [W-1:0] rval);
    logic ok;
    logic wr;
    int   c;
    ok = k != 0 && k <= TO;
    wr = is_d && we;
    c  = ok ? k : TO;
    hs_k = k;
    noise = nz;
    mem_val = rval;
    for (int n = 1; n <= c; n++) begin
      @(negedge clk);
      check("acc_rd", bus.readM, !wr);
      check("acc_wr", bus.writeM, wr);
      check("acc_addr", bus.address, addr);
      check("acc_data", data, wr ? wdata : rval);
      check("acc_busy", bus.busy, 1);
      check("acc_done", {bus.if_done, bus.d_done, bus.err}, 0);
      if (n == 1) begin
        if (is_d) begin
          bus.d_addr  = W'($urandom);
          bus.d_wdata = W'($urandom);
          bus.d_we    = 1'($urandom);
        end else bus.if_addr = W'($urandom);
      end
    end
    @(negedge clk);
    if (ok && !wr) begin
      if (is_d) exp_d_rdata = rval;
      else exp_if_rdata = rval;
    end
    check("done_if", bus.if_done, !is_d);
    check("done_d", bus.d_done, is_d);
    check("done_err", bus.err, !ok);
    check("done_strobe", {bus.readM, bus.writeM}, 0);
    check("done_addr", bus.address, 0);
    check("done_data", data, rval);
    check("done_busy", bus.busy, 1);
    check("done_ifr", bus.if_rdata, exp_if_rdata);
    check("done_dr", bus.d_rdata, exp_d_rdata);
    if (is_d) bus.d_req = 1'b0;
    else bus.if_req = 1'b0;
    @(negedge clk);
    check_quiet("idle");
  endtask
  initial begin
    int           kind;
    int           k1;
    int           k2;
    logic         nz;
    logic         we;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] w;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    #1 reset_n = 1'b1;
    #1 check_quiet("reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    check_quiet("post_reset");
    bus.if_addr = 16'h0010;
    bus.if_req = 1'b1;
    run_access(1'b0, 1'b0, 16'h0010, '0, 2, 1'b0, 16'h6A05);
    bus.d_we = 1'b1;
    bus.d_addr = 16'h0020;
    bus.d_wdata = 16'hBEEF;
    bus.d_req = 1'b1;
    run_access(1'b1, 1'b1, 16'h0020, 16'hBEEF, 3, 1'b1, 16'h0F00);
    bus.d_we = 1'b0;
    bus.d_addr = 16'h0030;
    bus.if_addr = 16'h0044;
    bus.d_req = 1'b1;
    bus.if_req = 1'b1;
    run_access(1'b1, 1'b0, 16'h0030, '0, 1, 1'b0, 16'h1234);
    run_access(1'b0, 1'b0, 16'h0044, '0, 2, 1'b1, 16'h5678);
    bus.d_we = 1'b0;
    bus.d_addr = 16'h0050;
    bus.d_req = 1'b1;
    run_access(1'b1, 1'b0, 16'h0050, '0, 0, 1'b0, 16'hDEAD);
    bus.if_addr = 16'h0070;
    bus.if_req = 1'b1;
    run_access(1'b0, 1'b0, 16'h0070, '0, TO, 1'b0, 16'h7777);
    bus.d_we = 1'b1;
    bus.d_addr = 16'h0060;
    bus.d_wdata = 16'hCAFE;
    bus.d_req = 1'b1;
    hs_k = 0;
    noise = 1'b0;
    mem_val = 16'h0F0F;
    @(negedge clk);
    check("rst_mid_wr1", bus.writeM, 1);
    @(negedge clk);
    check("rst_mid_wr2", data, 16'hCAFE);
    #2 reset_n = 1'b1;
    exp_if_rdata = '0;
    exp_d_rdata = '0;
    #1 check_quiet("rst_mid");
    bus.d_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_quiet("rst_hold");
    end
    reset_n = 1'b0;
    bus.d_we = 1'b1;
    bus.d_addr = 16'h0060;
    bus.d_wdata = 16'hCAFE;
    bus.d_req = 1'b1;
    run_access(1'b1, 1'b1, 16'h0060, 16'hCAFE, 2, 1'b1, 16'h0F0F);
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      k1 = $urandom_range(0, TO + 2);
      k2 = $urandom_range(0, TO + 2);
      nz = 1'($urandom);
      we = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      w = W'($urandom);
      if (kind == 0) begin
        bus.if_addr = a;
        bus.if_req = 1'b1;
        run_access(1'b0, 1'b0, a, '0, k1, nz, W'($urandom));
      end else begin
        we = kind == 1 ? 1'b0 : (kind == 2 ? 1'b1 : we);
        bus.d_we = we;
        bus.d_addr = b;
        bus.d_wdata = w;
        bus.d_req = 1'b1;
        bus.if_addr = a;
        bus.if_req = kind == 3;
        run_access(1'b1, we, b, w, k1, nz, W'($urandom));
        if (kind == 3) run_access(1'b0, 1'b0, a, '0, k2, !nz, W'($urandom));
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
